// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble deserializer front end.
package nibble_pkg;

    localparam int         WIDTH_DEFAULT = 4;
    localparam logic [7:0] DROP_MAX      = 8'd255;

    typedef enum logic [0:0] {
        UNSYNC = 1'b0,
        SHIFT  = 1'b1
    } state_t;

endpackage

// File: rtl/nibble_fifo.sv
// Small output FIFO: registered storage, combinational head read.
module nibble_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr[AW-1:0]] <= i_data;
                r_wptr                <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
        end
    end

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_data  = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/nibble_deserializer.sv
// Aligns a serial bit stream to frame markers and assembles WIDTH-bit words
// into an output FIFO with a valid/ready interface.
module nibble_deserializer
    import nibble_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter bit MSB_FIRST = 1'b1,
    parameter int DEPTH     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_bit,
    input  logic             s_valid,
    input  logic             s_frame,
    output logic             s_ready,
    output logic [WIDTH-1:0] a,
    output logic             a_valid,
    input  logic             a_ready,
    output logic             frame_err,
    output logic [7:0]       drop_count
);

    localparam int          CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_shift;
    logic             r_frame_err;
    logic [7:0]       r_drop;

    logic             w_full;
    logic             w_empty;
    logic             w_accept;
    logic             w_realign;
    logic             w_load;
    logic             w_push;
    logic [CW-1:0]    w_idx;
    logic [CW-1:0]    w_pos;
    logic [WIDTH-1:0] w_word;

    // Stall only on the final bit of a word, and only from registered state.
    assign s_ready   = !((r_count == LAST) && w_full);
    assign w_accept  = s_valid && s_ready;
    assign w_realign = w_accept && (r_state == SHIFT) && s_frame && (r_count != '0);
    assign w_load    = w_accept && ((r_state == SHIFT) || s_frame);
    assign w_push    = w_load && (r_state == SHIFT) && !w_realign && (r_count == LAST);
    assign w_idx     = w_realign ? '0 : r_count;
    assign w_pos     = MSB_FIRST ? (LAST - w_idx) : w_idx;

    // A word starting at index 0 begins from a clean register.
    always_comb begin
        w_word        = (w_idx == '0) ? '0 : r_shift;
        w_word[w_pos] = s_bit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= UNSYNC;
            r_count     <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
            r_drop      <= '0;
        end else begin
            if (w_load) begin
                r_shift <= w_word;
                r_state <= SHIFT;
                r_count <= w_push ? '0 : (w_idx + ONE);
            end
            if (w_realign) begin
                r_frame_err <= 1'b1;
                if (r_drop != DROP_MAX) begin
                    r_drop <= r_drop + 8'd1;
                end
            end
        end
    end

    nibble_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_word),
        .i_pop   (a_ready),
        .o_data  (a),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign a_valid    = !w_empty;
    assign frame_err  = r_frame_err;
    assign drop_count = r_drop;

endmodule

// File: tb/tb_nibble_deserializer.sv
// Scoreboard bench: two DUTs (MSB-first and LSB-first) share one serial stream
// and are checked against a bit-list reference model.
module tb_nibble_deserializer;

    localparam int W = 4;
    localparam int D = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic s_bit = 1'b0;
    logic s_valid = 1'b0;
    logic s_frame = 1'b0;
    logic a_ready = 1'b0;

    logic         sReadyM, aValidM, frameErrM;
    logic [W-1:0] aM;
    logic [7:0]   dropM;
    logic         sReadyL, aValidL, frameErrL;
    logic [W-1:0] aL;
    logic [7:0]   dropL;

    typedef struct {
        logic [W-1:0] msb;
        logic [W-1:0] lsb;
    } exp_t;

    exp_t expQ[$];

    // Reference model: sync flag, list of bits collected for the current word,
    // expected FIFO occupancy and sticky error state.
    bit mSync;
    bit mBits[$];
    int mOcc;
    bit mErr;
    int mDrop;

    int errors = 0;
    int checks = 0;

    nibble_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1), .DEPTH(D)) dutMsb (
        .clk        (clk),
        .reset      (reset),
        .s_bit      (s_bit),
        .s_valid    (s_valid),
        .s_frame    (s_frame),
        .s_ready    (sReadyM),
        .a          (aM),
        .a_valid    (aValidM),
        .a_ready    (a_ready),
        .frame_err  (frameErrM),
        .drop_count (dropM)
    );

    nibble_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0), .DEPTH(D)) dutLsb (
        .clk        (clk),
        .reset      (reset),
        .s_bit      (s_bit),
        .s_valid    (s_valid),
        .s_frame    (s_frame),
        .s_ready    (sReadyL),
        .a          (aL),
        .a_valid    (aValidL),
        .a_ready    (a_ready),
        .frame_err  (frameErrL),
        .drop_count (dropL)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit modelReady();
        return !(mSync && (mBits.size() == W - 1) && (mOcc == D));
    endfunction

    task automatic modelClear();
        mSync = 1'b0;
        mBits.delete();
        mOcc  = 0;
        mErr  = 1'b0;
        mDrop = 0;
        expQ.delete();
    endtask

    task automatic modelAccept(input bit b, input bit f, output int pushed);
        exp_t e;
        pushed = 0;
        if (!mSync) begin
            if (f) begin
                mSync = 1'b1;
                mBits.delete();
                mBits.push_back(b);
            end
        end else if (f && mBits.size() != 0) begin
            mErr = 1'b1;
            if (mDrop < 255) mDrop++;
            mBits.delete();
            mBits.push_back(b);
        end else begin
            mBits.push_back(b);
            if (mBits.size() == W) begin
                for (int i = 0; i < W; i++) begin
                    e.msb[W-1-i] = mBits[i];
                    e.lsb[i]     = mBits[i];
                end
                expQ.push_back(e);
                mBits.delete();
                pushed = 1;
            end
        end
    endtask

    // One clock cycle: drive inputs, check registered outputs, advance model.
    task automatic applyStimulus(input bit v, input bit b, input bit f, input bit ar);
        bit rdy;
        int pushed;
        s_valid = v;
        s_bit   = b;
        s_frame = f;
        a_ready = ar;
        #1;
        rdy = modelReady();
        checkOutput("s_ready", sReadyM, rdy);
        checkOutput("s_ready_lsb", sReadyL, rdy);
        checkOutput("a_valid", aValidM, mOcc > 0);
        checkOutput("a_valid_lsb", aValidL, mOcc > 0);
        checkOutput("frame_err", frameErrM, mErr);
        checkOutput("frame_err_lsb", frameErrL, mErr);
        checkOutput("drop_count", dropM, mDrop);
        checkOutput("drop_count_lsb", dropL, mDrop);
        @(posedge clk);
        pushed = 0;
        if (v && rdy) modelAccept(b, f, pushed);
        mOcc = mOcc + pushed - ((mOcc > 0 && ar) ? 1 : 0);
        #1;
    endtask

    task automatic sendBit(input bit b, input bit f, input bit ar);
        bit acc = 1'b0;
        int n = 0;
        while (!acc && n < 50) begin
            acc = modelReady();
            applyStimulus(1'b1, b, f, ar);
            n++;
        end
        if (!acc) checkOutput("sendBitTimeout", 0, 1);
    endtask

    task automatic sendWord(input logic [W-1:0] val, input bit firstFrame, input bit ar);
        for (int i = 0; i < W; i++) begin
            sendBit(val[W-1-i], firstFrame && (i == 0), ar);
        end
    endtask

    task automatic idle(input int n, input bit ar);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, ar);
    endtask

    // Reset lands between clock edges; outputs must clear without a clock.
    task automatic doReset();
        s_valid = 1'b0;
        s_frame = 1'b0;
        a_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rstA_valid", aValidM, 0);
        checkOutput("rstA_valid_lsb", aValidL, 0);
        checkOutput("rstFrameErr", frameErrM, 0);
        checkOutput("rstDropCount", dropM, 0);
        checkOutput("rstA", aM, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        modelClear();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset && aValidM && a_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedWord", aM, 32'hFFFF_FFFF);
            end else begin
                e = expQ.pop_front();
                checkOutput("wordMsb", aM, e.msb);
                checkOutput("wordLsb", aL, e.lsb);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        modelClear();
        #12;
        checkOutput("initA_valid", aValidM, 0);
        checkOutput("initFrameErr", frameErrM, 0);
        checkOutput("initDrop", dropM, 0);
        checkOutput("initA", aM, 0);
        checkOutput("initS_ready", sReadyM, 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] sync and assemble");
        sendBit(1'b1, 1'b0, 1'b1);
        sendBit(1'b0, 1'b0, 1'b1);
        sendBit(1'b1, 1'b0, 1'b1);
        sendWord(4'b1011, 1'b1, 1'b1);
        checkOutput("syncValid", aValidM, 1);
        checkOutput("syncWordMsb", aM, 4'b1011);
        checkOutput("syncWordLsb", aL, 4'b1101);
        sendWord(4'b1000, 1'b0, 1'b1);
        checkOutput("lsbOrderWord", aL, 4'b0001);

        $display("[TB] back-to-back stream");
        for (int n = 0; n < 16; n++) sendWord(W'(n), n == 0, 1'b1);
        idle(3, 1'b1);
        checkOutput("b2bFrameErr", frameErrM, 0);
        checkOutput("b2bDrop", dropM, 0);
        checkOutput("b2bDrained", expQ.size(), 0);

        $display("[TB] backpressure");
        doReset();
        sendWord(4'h3, 1'b1, 1'b0);
        sendWord(4'hA, 1'b0, 1'b0);
        sendBit(1'b0, 1'b0, 1'b0);
        sendBit(1'b1, 1'b0, 1'b0);
        sendBit(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("bpStall", sReadyM, 0);
        sendBit(1'b0, 1'b0, 1'b1);
        idle(6, 1'b1);
        checkOutput("bpDrained", expQ.size(), 0);

        $display("[TB] reset with full FIFO");
        sendWord(4'h5, 1'b1, 1'b0);
        sendWord(4'hC, 1'b0, 1'b0);
        sendBit(1'b1, 1'b0, 1'b0);
        doReset();
        sendBit(1'b1, 1'b0, 1'b1);
        sendBit(1'b1, 1'b0, 1'b1);
        sendBit(1'b0, 1'b0, 1'b1);
        sendWord(4'h9, 1'b1, 1'b1);
        checkOutput("postResetWord", aM, 4'h9);
        idle(3, 1'b1);

        $display("[TB] misaligned markers");
        doReset();
        sendWord(4'h5, 1'b1, 1'b1);
        for (int k = 0; k < 300; k++) begin
            sendBit(1'b1, 1'b0, 1'b1);
            sendBit(1'b0, 1'b0, 1'b1);
            sendWord(4'b1100, 1'b1, 1'b1);
            if (k == 0) begin
                checkOutput("misFrameErr", frameErrM, 1);
                checkOutput("misDrop1", dropM, 1);
                checkOutput("misWord", aM, 4'b1100);
            end
        end
        checkOutput("dropSaturated", dropM, 255);
        idle(3, 1'b1);

        $display("[TB] randomized stream");
        doReset();
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) doReset();
            applyStimulus($urandom_range(0, 3) != 0, 1'($urandom),
                          $urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0);
        end
        idle(8, 1'b1);
        checkOutput("finalQueueEmpty", expQ.size(), 0);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
